// File: rtl/gate_tt_pkg.sv
// Shared constants for the 2-input gate truth-table checker: reference tables
// (bit index = {A,B}) and the checker FSM state encoding.
package gate_tt_pkg;

  localparam logic [3:0] TT_NAND = 4'b0111;
  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_NOR  = 4'b0001;
  localparam logic [3:0] TT_XOR  = 4'b0110;
  localparam logic [3:0] TT_XNOR = 4'b1001;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/gate_tt_checker_if.sv
// Bundle between the checker and the gate under test / the controlling host.
// start is a single-cycle request with no ready: it is taken on any edge where the
// checker is in IDLE or DONE and silently dropped while a sweep runs (watch busy).
interface gate_tt_checker_if #(
  parameter int ERR_W = 8
);
  logic             start;
  logic             drv_a;
  logic             drv_b;
  logic             dut_y;
  logic             busy;
  logic             done;
  logic             pass;
  logic [ERR_W-1:0] err_count;
  logic             first_fail_valid;
  logic [1:0]       first_fail_vec;

  modport master (
    input  start, dut_y,
    output drv_a, drv_b, busy, done, pass, err_count, first_fail_valid, first_fail_vec
  );

  modport slave (
    output start, dut_y,
    input  drv_a, drv_b, busy, done, pass, err_count, first_fail_valid, first_fail_vec
  );
endinterface

// File: rtl/gate_tt_vec_gen.sv
// Settle / vector / pass counters for the sweep. Emits the current {A,B} vector,
// a strobe on the edge where dut_y is sampled, and a strobe on the final sample.
module gate_tt_vec_gen #(
  parameter int SETTLE_CYCLES = 2,
  parameter int N_PASSES      = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       run,
  output logic [1:0] vec,
  output logic       sample_strobe,
  output logic       last_strobe
);

  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int PW = (N_PASSES > 1) ? $clog2(N_PASSES) : 1;
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [PW-1:0] PASS_LAST   = PW'(N_PASSES - 1);

  logic [SW-1:0] settle_cnt;
  logic [PW-1:0] pass_cnt;

  assign sample_strobe = run && (settle_cnt == SETTLE_LAST);
  assign last_strobe   = sample_strobe && (vec == 2'b11) && (pass_cnt == PASS_LAST);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      settle_cnt <= '0;
      vec        <= 2'b00;
      pass_cnt   <= '0;
    end else if (run) begin
      if (sample_strobe) begin
        settle_cnt <= '0;
        // Final sample parks the drivers at 00; otherwise step and wrap the vector.
        if (last_strobe) begin
          vec      <= 2'b00;
          pass_cnt <= '0;
        end else begin
          vec <= vec + 2'd1;
          if (vec == 2'b11) pass_cnt <= pass_cnt + 1'b1;
        end
      end else begin
        settle_cnt <= settle_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/gate_tt_checker.sv
// Exhaustive truth-table checker for a 2-input gate: sweeps {A,B}, compares the gate
// output against TRUTH_TABLE, and reports pass, a saturating error count and first failure.
module gate_tt_checker
  import gate_tt_pkg::*;
#(
  parameter logic [3:0] TRUTH_TABLE   = TT_NAND,
  parameter int         SETTLE_CYCLES = 2,
  parameter int         N_PASSES      = 1,
  parameter int         ERR_W         = 8
) (
  input  logic                clk,
  input  logic                rst,
  gate_tt_checker_if.master   bus,
  output state_t              state_dbg
);

  state_t           state;
  logic [1:0]       vec;
  logic             sample_strobe;
  logic             last_strobe;
  logic             start_ok;
  logic             mismatch;
  logic [ERR_W-1:0] err_count;
  logic [ERR_W-1:0] err_next;
  logic             busy_q, done_q, pass_q, ff_valid_q;
  logic [1:0]       ff_vec_q;

  assign start_ok = bus.start && ((state == ST_IDLE) || (state == ST_DONE));
  assign mismatch = sample_strobe && (bus.dut_y != TRUTH_TABLE[vec]);
  assign err_next = (mismatch && (err_count != {ERR_W{1'b1}})) ? err_count + 1'b1 : err_count;

  gate_tt_vec_gen #(
    .SETTLE_CYCLES (SETTLE_CYCLES),
    .N_PASSES      (N_PASSES)
  ) u_vec_gen (
    .clk           (clk),
    .rst           (rst),
    .clear         (start_ok),
    .run           (state == ST_RUN),
    .vec           (vec),
    .sample_strobe (sample_strobe),
    .last_strobe   (last_strobe)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      err_count  <= '0;
      ff_valid_q <= 1'b0;
      ff_vec_q   <= 2'b00;
    end else if (start_ok) begin
      state      <= ST_RUN;
      busy_q     <= 1'b1;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      err_count  <= '0;
      ff_valid_q <= 1'b0;
      ff_vec_q   <= 2'b00;
    end else if (state == ST_RUN) begin
      err_count <= err_next;
      if (mismatch && !ff_valid_q) begin
        ff_valid_q <= 1'b1;
        ff_vec_q   <= vec;
      end
      // pass must reflect the mismatch from this final sample, hence err_next.
      if (last_strobe) begin
        state  <= ST_DONE;
        busy_q <= 1'b0;
        done_q <= 1'b1;
        pass_q <= (err_next == '0);
      end
    end
  end

  assign bus.drv_a            = vec[1];
  assign bus.drv_b            = vec[0];
  assign bus.busy             = busy_q;
  assign bus.done             = done_q;
  assign bus.pass             = pass_q;
  assign bus.err_count        = err_count;
  assign bus.first_fail_valid = ff_valid_q;
  assign bus.first_fail_vec   = ff_vec_q;
  assign state_dbg            = state;

endmodule

// File: tb/tb_gate_tt_checker.sv
// Directed bench for gate_tt_checker: NAND reference, stuck-at gates, start handling,
// mid-sweep reset, and a saturating multi-pass instance.
module tb_gate_tt_checker;
  import gate_tt_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int mode     = 0;  // 0: real NAND, 1: stuck-at-1, 2: stuck-at-0

  gate_tt_checker_if #(.ERR_W(8)) if_a ();
  gate_tt_checker_if #(.ERR_W(2)) if_b ();
  state_t st_a, st_b;

  assign if_a.dut_y = (mode == 0) ? ~(if_a.drv_a & if_a.drv_b) : (mode == 1);
  assign if_b.dut_y = 1'b0;

  gate_tt_checker #(
    .TRUTH_TABLE(TT_NAND), .SETTLE_CYCLES(2), .N_PASSES(1), .ERR_W(8)
  ) u_dut_a (
    .clk(clk), .rst(rst), .bus(if_a.master), .state_dbg(st_a)
  );

  gate_tt_checker #(
    .TRUTH_TABLE(TT_NAND), .SETTLE_CYCLES(2), .N_PASSES(4), .ERR_W(2)
  ) u_dut_b (
    .clk(clk), .rst(rst), .bus(if_b.master), .state_dbg(st_b)
  );

  // ---------------- driver tasks ----------------
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start(input bit inst_b);
    if (inst_b) if_b.start = 1'b1; else if_a.start = 1'b1;
    tick();
    if_a.start = 1'b0;
    if_b.start = 1'b0;
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic check_result_a(input string tag, input bit exp_pass, input int exp_err,
                                input bit exp_ffv, input logic [1:0] exp_ffvec);
    check({tag, ".done"}, 32'(if_a.done), 32'd1);
    check({tag, ".busy"}, 32'(if_a.busy), 32'd0);
    check({tag, ".pass"}, 32'(if_a.pass), 32'(exp_pass));
    check({tag, ".err"},  32'(if_a.err_count), 32'(exp_err));
    check({tag, ".ffv"},  32'(if_a.first_fail_valid), 32'(exp_ffv));
    check({tag, ".ffvec"}, 32'(if_a.first_fail_vec), 32'(exp_ffvec));
    check({tag, ".drv"},  32'({if_a.drv_a, if_a.drv_b}), 32'd0);
    check({tag, ".state"}, 32'(st_a), 32'(ST_DONE));
  endtask

  // Sweep on instance A with a fixed 8-cycle latency from the start edge.
  task automatic run_a(input string tag);
    pulse_start(1'b0);
    tick(7);
    check({tag, ".done_early"}, 32'(if_a.done), 32'd0);
    tick();
    check({tag, ".done_at8"}, 32'(if_a.done), 32'd1);
  endtask

  task automatic check_reset_a(input string tag);
    check({tag, ".state"}, 32'(st_a), 32'(ST_IDLE));
    check({tag, ".drv"},  32'({if_a.drv_a, if_a.drv_b}), 32'd0);
    check({tag, ".busy"}, 32'(if_a.busy), 32'd0);
    check({tag, ".done"}, 32'(if_a.done), 32'd0);
    check({tag, ".pass"}, 32'(if_a.pass), 32'd0);
    check({tag, ".err"},  32'(if_a.err_count), 32'd0);
    check({tag, ".ffv"},  32'(if_a.first_fail_valid), 32'd0);
    check({tag, ".ffvec"}, 32'(if_a.first_fail_vec), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    if_a.start = 1'b0;
    if_b.start = 1'b0;
    tick(3);
    rst = 1'b0;
    check_reset_a("reset");
    check("reset.b_state", 32'(st_b), 32'(ST_IDLE));
    check("reset.b_err", 32'(if_b.err_count), 32'd0);

    // 1: real NAND, watch the drive sequence cycle by cycle.
    mode = 0;
    pulse_start(1'b0);
    check("t1.busy", 32'(if_a.busy), 32'd1);
    for (int k = 0; k < 8; k++) begin
      check($sformatf("t1.drv%0d", k), 32'({if_a.drv_a, if_a.drv_b}), 32'(k / 2));
      check($sformatf("t1.done%0d", k), 32'(if_a.done), 32'd0);
      tick();
    end
    check_result_a("t1", 1'b1, 0, 1'b0, 2'b00);

    // 2: stuck-at-1 only disagrees on 11.
    mode = 1;
    run_a("t2");
    check_result_a("t2", 1'b0, 1, 1'b1, 2'b11);

    // 3: stuck-at-0 disagrees on 00, 01, 10.
    mode = 2;
    run_a("t3");
    check_result_a("t3", 1'b0, 3, 1'b1, 2'b00);

    // 4a: start re-pulsed during RUN is ignored.
    mode = 0;
    pulse_start(1'b0);
    tick(2);
    if_a.start = 1'b1;
    tick();
    if_a.start = 1'b0;
    tick(4);
    check("t4.done_early", 32'(if_a.done), 32'd0);
    tick();
    check("t4.done_at8", 32'(if_a.done), 32'd1);
    check_result_a("t4a", 1'b1, 0, 1'b0, 2'b00);

    // 4b: start from DONE after a failing sweep clears the results.
    mode = 2;
    run_a("t4b_fail");
    check("t4b.err_before", 32'(if_a.err_count), 32'd3);
    mode = 0;
    pulse_start(1'b0);
    check("t4b.busy", 32'(if_a.busy), 32'd1);
    check("t4b.done", 32'(if_a.done), 32'd0);
    check("t4b.err_clr", 32'(if_a.err_count), 32'd0);
    check("t4b.ffv_clr", 32'(if_a.first_fail_valid), 32'd0);
    check("t4b.state", 32'(st_a), 32'(ST_RUN));
    tick(8);
    check_result_a("t4b", 1'b1, 0, 1'b0, 2'b00);

    // 5: reset while vector 10 is driven, then a clean sweep.
    mode = 2;
    pulse_start(1'b0);
    tick(4);
    check("t5.drv10", 32'({if_a.drv_a, if_a.drv_b}), 32'd2);
    check("t5.err_mid", 32'(if_a.err_count), 32'd2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_a("t5.rst");
    mode = 0;
    run_a("t5");
    check_result_a("t5", 1'b1, 0, 1'b0, 2'b00);

    // 6: four passes, 12 mismatches, 2-bit counter saturates at 3.
    pulse_start(1'b1);
    check("t6.busy", 32'(if_b.busy), 32'd1);
    tick(31);
    check("t6.done_early", 32'(if_b.done), 32'd0);
    tick();
    check("t6.done_at32", 32'(if_b.done), 32'd1);
    check("t6.busy_end", 32'(if_b.busy), 32'd0);
    check("t6.err_sat", 32'(if_b.err_count), 32'd3);
    check("t6.pass", 32'(if_b.pass), 32'd0);
    check("t6.ffv", 32'(if_b.first_fail_valid), 32'd1);
    check("t6.ffvec", 32'(if_b.first_fail_vec), 32'd0);
    check("t6.state", 32'(st_b), 32'(ST_DONE));

    // ---------------- report ----------------
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
